hpi_burst_master: RTL and testbench

HPI_BURST_MASTER -- requirements
Module: hpi_burst_master

---
 rtl/hpi_pkg.sv | 25 ++
 rtl/hpi_access_timer.sv | 30 +++
 rtl/hpi_burst_master.sv | 159 +++++++++++++++
 tb/tb_hpi_burst_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// Shared HPI definitions: register codes, engine states and default timing.
package hpi_pkg;

  localparam logic [1:0] HpiRegData    = 2'd0;
  localparam logic [1:0] HpiRegMailbox = 2'd1;
  localparam logic [1:0] HpiRegAddress = 2'd2;
  localparam logic [1:0] HpiRegStatus  = 2'd3;

  localparam int unsigned DefDataW     = 16;
  localparam int unsigned DefMaxBurst  = 16;
  localparam int unsigned DefStrobeCyc = 4;
  localparam int unsigned DefSetupCyc  = 1;
  localparam int unsigned DefRecovCyc  = 2;
  localparam int unsigned TimerW       = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StRecov,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/hpi_access_timer.sv
// Loadable down-counter timing one access phase; tc_o marks the phase's last cycle.
module hpi_access_timer
  import hpi_pkg::*;
#(
  parameter int unsigned Width = TimerW
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o,
  output logic             zero_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign tc_o   = (count_q == Width'(1));
  assign zero_o = (count_q == '0);

endmodule

// File: rtl/hpi_burst_master.sv
// HPI burst engine: address phase then up to MAX_BURST data accesses, stream-side handshakes.
module hpi_burst_master
  import hpi_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned MAX_BURST  = DefMaxBurst,
  parameter int unsigned STROBE_CYC = DefStrobeCyc,
  parameter int unsigned SETUP_CYC  = DefSetupCyc,
  parameter int unsigned RECOV_CYC  = DefRecovCyc,
  parameter int unsigned LEN_W      = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [15:0]       cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic              otg_hpi_cs_n,
  output logic [1:0]        otg_hpi_address,
  output logic              otg_hpi_r_n,
  output logic              otg_hpi_w_n,
  output logic [DATA_W-1:0] otg_hpi_data_out,
  output logic              otg_hpi_data_oe,
  input  logic [DATA_W-1:0] otg_hpi_data_in
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_q, word_d;
  logic              timer_load, timer_tc, timer_zero;
  logic [TimerW-1:0] timer_val;
  logic              accept, wr_take, rd_ack, capture, last_word;
  logic              hpi_active_d, wr_access_d;

  hpi_access_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .tc_o      (timer_tc),
    .zero_o    (timer_zero)
  );

  assign accept    = cmd_valid & cmd_ready;
  assign wr_take   = wr_valid & wr_ready;
  assign rd_ack    = rd_valid & rd_ready;
  assign last_word = (word_q == len_q);
  // Word 0 is the address phase, so only data words are captured.
  assign capture   = (state_q == StStrobe) && timer_tc && !write_q && (word_q != '0);

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    len_d      = len_q;
    word_d     = word_q;
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
          write_d = cmd_write;
          word_d  = '0;
          len_d   = (cmd_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : cmd_len;
        end
      end
      StSetup:  if (timer_tc) state_d = StStrobe;
      StStrobe: if (timer_tc) state_d = StRecov;
      StRecov: begin
        // Recovery stretches while the final read word is still unacknowledged.
        if (timer_tc || timer_zero) begin
          if (!last_word) begin
            state_d = StWait;
            word_d  = word_q + LEN_W'(1);
          end else if (!rd_valid) begin
            state_d = StDone;
          end
        end
      end
      StWait: begin
        if (write_q ? wr_take : (!rd_valid || rd_ack)) state_d = StSetup;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      timer_load = 1'b1;
      case (state_d)
        StSetup:  timer_val = TimerW'(SETUP_CYC);
        StStrobe: timer_val = TimerW'(STROBE_CYC);
        StRecov:  timer_val = TimerW'(RECOV_CYC);
        default:  timer_load = 1'b0;
      endcase
    end
  end

  assign hpi_active_d = (state_d == StSetup) || (state_d == StStrobe);
  assign wr_access_d  = (word_d == '0) || write_d;

  // Outputs are registered from next-state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      write_q          <= 1'b0;
      len_q            <= '0;
      word_q           <= '0;
      cmd_ready        <= 1'b0;
      wr_ready         <= 1'b0;
      rd_data          <= '0;
      rd_valid         <= 1'b0;
      done             <= 1'b0;
      otg_hpi_cs_n     <= 1'b1;
      otg_hpi_address  <= 2'd0;
      otg_hpi_r_n      <= 1'b1;
      otg_hpi_w_n      <= 1'b1;
      otg_hpi_data_out <= '0;
      otg_hpi_data_oe  <= 1'b0;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      len_q           <= len_d;
      word_q          <= word_d;
      cmd_ready       <= (state_d == StIdle);
      wr_ready        <= (state_d == StWait) && write_d;
      done            <= (state_d == StDone);
      otg_hpi_cs_n    <= !hpi_active_d;
      otg_hpi_w_n     <= !((state_d == StStrobe) && wr_access_d);
      otg_hpi_r_n     <= !((state_d == StStrobe) && !wr_access_d);
      otg_hpi_data_oe <= hpi_active_d && wr_access_d;
      if (state_d == StSetup) begin
        otg_hpi_address <= (word_d == '0) ? HpiRegAddress : HpiRegData;
      end
      if (accept) begin
        otg_hpi_data_out <= DATA_W'(cmd_addr);
      end else if (wr_take) begin
        otg_hpi_data_out <= wr_data;
      end
      if (capture) begin
        rd_data  <= otg_hpi_data_in;
        rd_valid <= 1'b1;
      end else if (rd_ack) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hpi_burst_master.sv
// Scoreboard bench: expected HPI accesses and read words queued at issue, checked by a monitor.
module tb_hpi_burst_master;

  localparam int DW = 16;
  localparam int MB = 16;
  localparam int SC = 4;
  localparam int SU = 1;
  localparam int RC = 2;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [15:0]   cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          done;
  logic          cs_n;
  logic [1:0]    hpi_addr;
  logic          r_n;
  logic          w_n;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic [DW-1:0] data_in;

  always #5 clk = ~clk;

  hpi_burst_master #(
    .DATA_W    (DW),
    .MAX_BURST (MB),
    .STROBE_CYC(SC),
    .SETUP_CYC (SU),
    .RECOV_CYC (RC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .done            (done),
    .otg_hpi_cs_n    (cs_n),
    .otg_hpi_address (hpi_addr),
    .otg_hpi_r_n     (r_n),
    .otg_hpi_w_n     (w_n),
    .otg_hpi_data_out(data_out),
    .otg_hpi_data_oe (data_oe),
    .otg_hpi_data_in (data_in)
  );

  typedef struct {
    bit        wr;
    bit [1:0]  addr;
    bit [15:0] data;
  } acc_t;

  acc_t        exp_q[$];
  logic [15:0] rd_exp_q[$];
  logic [15:0] wr_words[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          rd_idx = 0;
  logic [15:0] rd_base = '0;

  // Device model: successive data reads return rd_base+1, rd_base+2, ...
  assign data_in = rd_base + 16'(rd_idx) + 16'd1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Bus monitor: measures setup/strobe lengths and scores each completed access.
  int   low_cnt = 0;
  int   setup_cnt = 0;
  logic in_strobe = 1'b0;
  acc_t cur;
  acc_t e;
  always @(negedge clk) begin
    if (reset) begin
      low_cnt   = 0;
      setup_cnt = 0;
      in_strobe = 1'b0;
    end else begin
      if (!w_n || !r_n) begin
        if (!in_strobe) begin
          in_strobe = 1'b1;
          cur.wr    = !w_n;
          cur.addr  = hpi_addr;
          cur.data  = data_out;
          check("setup_len", setup_cnt, SU);
          check("strobe_oe", data_oe, !w_n);
        end
        check("strobe_cs_n", cs_n, 0);
        low_cnt++;
      end else begin
        if (in_strobe) begin
          check("strobe_len", low_cnt, SC);
          check("access_queued", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("acc_write", cur.wr, e.wr);
            check("acc_reg", cur.addr, e.addr);
            if (e.wr) check("acc_data", cur.data, e.data);
          end
          if (cur.addr == 2'd2) rd_idx = 0;
          else if (!cur.wr) rd_idx++;
          in_strobe = 1'b0;
          low_cnt   = 0;
        end
        if (!cs_n) setup_cnt++;
        else setup_cnt = 0;
      end
      if (done) done_cnt++;
    end
  end

  task automatic issue(input bit wr, input logic [15:0] addr, input int len);
    acc_t a;
    int   n = (len > MB) ? MB : len;
    a.wr = 1'b1; a.addr = 2'd2; a.data = addr;
    exp_q.push_back(a);
    for (int k = 0; k < n; k++) begin
      a.wr = wr; a.addr = 2'd0; a.data = wr ? wr_words[k] : 16'h0;
      exp_q.push_back(a);
      if (!wr) rd_exp_q.push_back(rd_base + 16'(k) + 16'd1);
    end
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    for (int t = 0; t < 200 && !cmd_ready; t++) @(negedge clk);
    check("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic feed(input int delay);
    for (int k = 0; k < wr_words.size(); k++) begin
      for (int t = 0; t < 200 && !wr_ready; t++) @(negedge clk);
      check("wr_ready_wait", wr_ready, 1);
      if (!wr_ready) return;
      if (k == 0) begin
        for (int d = 0; d < delay; d++) begin
          @(negedge clk);
          check("starve_wr_ready", wr_ready, 1);
          check("starve_cs_n", cs_n, 1);
          check("starve_w_n", w_n, 1);
        end
      end
      @(negedge clk);
      wr_data  = wr_words[k];
      wr_valid = 1'b1;
      @(posedge clk);
      #1 wr_valid = 1'b0;
    end
  endtask

  task automatic consume(input int n, input int stall);
    logic [15:0] held;
    for (int k = 0; k < n; k++) begin
      for (int t = 0; t < 200 && !rd_valid; t++) @(negedge clk);
      check("rd_valid_wait", rd_valid, 1);
      if (!rd_valid) return;
      if (k == 0 && stall > 0) begin
        held = rd_data;
        for (int d = 0; d < stall; d++) begin
          @(negedge clk);
          check("bp_cs_n", cs_n, 1);
          check("bp_rd_data", rd_data, held);
          check("bp_rd_valid", rd_valid, 1);
        end
      end
      check("rd_word_expected", int'(rd_exp_q.size() > 0), 1);
      if (rd_exp_q.size() > 0) check("rd_data", rd_data, rd_exp_q.pop_front());
      @(negedge clk);
      rd_ready = 1'b1;
      @(posedge clk);
      #1 rd_ready = 1'b0;
    end
  endtask

  task automatic finish_cmd(input string tag, input int target);
    for (int t = 0; t < 300 && done_cnt < target; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_done"}, done_cnt, target);
    check({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_r_n", r_n, 1);
    check("rst_w_n", w_n, 1);
    check("rst_addr", hpi_addr, 0);
    check("rst_data_out", data_out, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_oe", data_oe, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_done", done, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);

    wr_words = '{16'hBEEF, 16'hCAFE};
    issue(1'b1, 16'h1000, 2);
    feed(0);
    finish_cmd("wr_burst", 1);

    rd_base = 16'h0000;
    issue(1'b0, 16'h0040, 3);
    consume(3, 0);
    finish_cmd("rd_burst", 2);

    rd_base = 16'h0100;
    issue(1'b0, 16'h0080, 2);
    consume(2, 10);
    finish_cmd("rd_bp", 3);

    wr_words = '{16'h1234};
    issue(1'b1, 16'h2000, 1);
    feed(7);
    finish_cmd("wr_starve", 4);

    issue(1'b0, 16'h3000, 0);
    finish_cmd("addr_only", 5);

    rd_base = 16'h0200;
    issue(1'b0, 16'h4000, 20);
    consume(16, 0);
    finish_cmd("saturate", 6);
    check("rd_words_left", rd_exp_q.size(), 0);

    wr_words = '{16'h5555, 16'h6666};
    issue(1'b1, 16'h5000, 2);
    for (int t = 0; t < 50 && w_n; t++) @(negedge clk);
    check("abort_strobe_seen", w_n, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_w_n", w_n, 1);
    check("abort_r_n", r_n, 1);
    check("abort_cs_n", cs_n, 1);
    check("abort_rd_valid", rd_valid, 0);
    exp_q.delete();
    rd_exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    check("abort_cmd_ready", cmd_ready, 1);
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
